// File: rtl/cache_pkg.sv
// cache_pkg: shared controller state encoding and default bus widths
package cache_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, FILL, RESP} cache_ctrl_state_t;
endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU load/store port and memory port; slave = controller view, master = CPU/memory view
interface cache_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              cpu_req, cpu_we, cpu_ready, cpu_err, cpu_busy;
  logic [ADDR_W-1:0] cpu_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic              mem_req, mem_we, mem_ack;
  modport slave (input cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
                 output cpu_rdata, cpu_ready, cpu_err, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata);
  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
                  input cpu_rdata, cpu_ready, cpu_err, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/cache_ctrl_sat_counter.sv
// sat_counter: W-bit counter (clk, rst, i_inc -> o_count) that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk)
    r_count <= rst ? '0 : r_count + W'(i_inc && !(&r_count));
  assign o_count = r_count;
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: CPU/cache/memory sequencer; ports clk, rst, bus (CPU+memory), o_c_* / i_c_* cache array, o_hit_cnt/o_miss_cnt
module cache_ctrl import cache_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  cache_ctrl_if.slave       bus,
  output logic [ADDR_W-1:0] o_c_addr,
  output logic [DATA_W-1:0] o_c_wdata,
  output logic              o_c_we,
  input  logic [DATA_W-1:0] i_c_rdata,
  input  logic              i_c_hit,
  output logic [CNT_W-1:0]  o_hit_cnt,
  output logic [CNT_W-1:0]  o_miss_cnt
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  cache_ctrl_state_t r_state, w_next;
  logic              r_we, r_err, r_ready, r_cerr, r_mem_req, r_mem_we, r_c_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_data, r_rdata;
  logic [TW-1:0]     r_cnt;
  logic              w_mem, w_ack, w_tmo, w_hit, w_miss;
  assign w_mem  = r_state == MEM_RD || r_state == MEM_WR;
  assign w_ack  = w_mem && bus.mem_ack;
  // an ack arriving in the final wait cycle wins over the timeout
  assign w_tmo  = w_mem && !bus.mem_ack && r_cnt == TW'(MEM_TIMEOUT - 1);
  assign w_hit  = r_state == LOOKUP && i_c_hit;
  assign w_miss = r_state == LOOKUP && !i_c_hit;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:           w_next = bus.cpu_req ? LOOKUP : IDLE;
      LOOKUP:         w_next = r_we ? MEM_WR : i_c_hit ? RESP : MEM_RD;
      MEM_RD, MEM_WR: w_next = w_ack ? FILL : w_tmo ? RESP : r_state;
      FILL:           w_next = RESP;
      default:        w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_c_we    <= 1'b0;
      r_ready   <= 1'b0;
      r_cerr    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_state == IDLE && bus.cpu_req) begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
        r_data  <= bus.cpu_we ? bus.cpu_wdata : '0;
      end
      if (w_hit && !r_we) r_data <= i_c_rdata;
      if (w_ack && r_state == MEM_RD) r_data <= bus.mem_rdata;
      r_cnt     <= w_mem ? r_cnt + TW'(1) : '0;
      r_err     <= w_tmo || (r_err && r_state != RESP);
      // memory and fill strobes follow the next state so they line up with it
      r_mem_req <= w_next == MEM_RD || w_next == MEM_WR;
      r_mem_we  <= w_next == MEM_WR;
      r_c_we    <= w_next == FILL;
      r_ready   <= r_state == RESP;
      r_cerr    <= r_state == RESP && r_err;
      r_rdata   <= (r_state == RESP && !r_we) ? r_data : '0;
    end
  end
  sat_counter #(.W(CNT_W)) u_hit  (.clk(clk), .rst(rst), .i_inc(w_hit),  .o_count(o_hit_cnt));
  sat_counter #(.W(CNT_W)) u_miss (.clk(clk), .rst(rst), .i_inc(w_miss), .o_count(o_miss_cnt));
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_ready = r_ready;
  assign bus.cpu_err   = r_cerr;
  assign bus.cpu_busy  = r_state != IDLE;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_c_addr      = r_addr;
  assign o_c_wdata     = r_data;
  assign o_c_we        = r_c_we;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized and directed checks of cache_ctrl against a memory/cache reference model
module tb_cache_ctrl;
  localparam int T = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  cache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic c_we, c_hit;
  logic [3:0] hit_cnt, miss_cnt;
  logic cvalid [256];
  logic [31:0] cdata [256];
  logic [31:0] mdata [256];
  assign c_hit   = cvalid[c_addr[9:2]];
  assign c_rdata = cdata[c_addr[9:2]];
  cache_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_TIMEOUT(T), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_c_addr(c_addr), .o_c_wdata(c_wdata), .o_c_we(c_we),
    .i_c_rdata(c_rdata), .i_c_hit(c_hit), .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt));
  int vectors = 0, miscompares = 0;
  int ack_dly = 0, n_req_cyc, n_cwe, n_bad;
  logic r_ack, stray_ack = 1'b0;
  logic [31:0] last_cwdata, cur_addr = 0, cur_wdata = 0;
  logic cur_we = 1'b0;
  bit ref_valid [256];
  logic [31:0] ref_mem [256];
  int ref_hit = 0, ref_miss = 0;
  assign bus.mem_ack = r_ack | stray_ack;

  function automatic logic [31:0] init_word(int i);
    return (i == 65) ? 32'hDEADBEEF : 32'hA5000000 + 32'(i) * 32'd7;
  endfunction

  // cache array + memory: cache writes land on c_we, memory acks after ack_dly wait cycles (never if <0)
  initial begin : env
    int wait_n;
    wait_n = 0; n_req_cyc = 0; n_cwe = 0; n_bad = 0; r_ack = 1'b0; last_cwdata = 0;
    bus.mem_rdata = 0;
    for (int i = 0; i < 256; i++) begin cvalid[i] = 1'b0; cdata[i] = 0; mdata[i] = init_word(i); end
    forever begin
      @(negedge clk);
      if (c_we) begin
        cvalid[c_addr[9:2]] = 1'b1; cdata[c_addr[9:2]] = c_wdata; n_cwe++; last_cwdata = c_wdata;
      end
      r_ack = 1'b0;
      if (bus.mem_req) begin
        n_req_cyc++;
        if (bus.mem_addr !== cur_addr || bus.mem_we !== cur_we || (cur_we && bus.mem_wdata !== cur_wdata)) n_bad++;
        if (wait_n == ack_dly) begin
          r_ack = 1'b1; wait_n = 0;
          if (bus.mem_we) mdata[bus.mem_addr[9:2]] = bus.mem_wdata;
          else bus.mem_rdata = mdata[bus.mem_addr[9:2]];
        end else wait_n++;
      end else wait_n = 0;
    end
  end

  task automatic check_req(input logic we, input int idx, input logic [31:0] wd, input int dly, input string tag);
    logic [31:0] a, exp_rd;
    bit hit, mem, err, got;
    int exp_lat, exp_cyc, exp_cwe, n, c0, r0, b0;
    a = 32'(idx * 4);
    hit = ref_valid[idx];
    mem = we || !hit;
    err = mem && (dly < 0 || dly >= T);
    exp_lat = !mem ? 2 : err ? 2 + T : 4 + dly;
    exp_cyc = !mem ? 0 : err ? T : dly + 1;
    exp_cwe = (mem && !err) ? 1 : 0;
    exp_rd = we ? wd : ref_mem[idx];
    if (mem && !err) begin ref_mem[idx] = exp_rd; ref_valid[idx] = 1'b1; end
    if (hit) ref_hit = (ref_hit < 15) ? ref_hit + 1 : 15;
    else ref_miss = (ref_miss < 15) ? ref_miss + 1 : 15;
    @(negedge clk);
    ack_dly = dly; cur_addr = a; cur_we = we; cur_wdata = wd;
    c0 = n_cwe; r0 = n_req_cyc; b0 = n_bad;
    vectors++;
    if (bus.cpu_busy !== 1'b0) begin miscompares++; $display("FAIL %s idle_busy got=%b exp=0", tag, bus.cpu_busy); end
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(negedge clk); n++;
      if (bus.cpu_ready) got = 1;
      else bus.cpu_req = (n < 1) ? 1'b1 : 1'b0;
      if (n == 1) begin
        vectors++;
        if (bus.cpu_busy !== 1'b1) begin miscompares++; $display("FAIL %s busy got=%b exp=1", tag, bus.cpu_busy); end
      end
    end
    bus.cpu_req = 1'b0;
    vectors++;
    if (!got || n - 1 != exp_lat) begin miscompares++; $display("FAIL %s latency got=%0d exp=%0d ready=%b", tag, n - 1, exp_lat, got); end
    vectors++;
    if (bus.cpu_err !== err) begin miscompares++; $display("FAIL %s err got=%b exp=%b", tag, bus.cpu_err, err); end
    if (!err) begin
      vectors++;
      if (bus.cpu_rdata !== (we ? 32'h0 : exp_rd)) begin miscompares++; $display("FAIL %s rdata got=%h exp=%h", tag, bus.cpu_rdata, we ? 32'h0 : exp_rd); end
    end
    vectors++;
    if (hit_cnt !== 4'(ref_hit) || miss_cnt !== 4'(ref_miss)) begin
      miscompares++; $display("FAIL %s counters got=%0d/%0d exp=%0d/%0d", tag, hit_cnt, miss_cnt, ref_hit, ref_miss);
    end
    vectors++;
    if (n_req_cyc - r0 != exp_cyc) begin miscompares++; $display("FAIL %s mem_req_cycles got=%0d exp=%0d", tag, n_req_cyc - r0, exp_cyc); end
    vectors++;
    if (n_bad != b0) begin miscompares++; $display("FAIL %s mem_bus_unstable got=%0d exp=0", tag, n_bad - b0); end
    vectors++;
    if (n_cwe - c0 != exp_cwe) begin miscompares++; $display("FAIL %s c_we_pulses got=%0d exp=%0d", tag, n_cwe - c0, exp_cwe); end
    if (exp_cwe == 1) begin
      vectors++;
      if (last_cwdata !== exp_rd) begin miscompares++; $display("FAIL %s c_wdata got=%h exp=%h", tag, last_cwdata, exp_rd); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.cpu_ready, bus.cpu_err, bus.cpu_busy, bus.mem_req, c_we} !== 5'b0 || bus.cpu_rdata !== 32'h0 || bus.mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_outputs got=%b%b%b%b%b rdata=%h exp=0", bus.cpu_ready, bus.cpu_err, bus.cpu_busy, bus.mem_req, c_we, bus.cpu_rdata);
    end
    vectors++;
    if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    rst = 1'b0; ref_hit = 0; ref_miss = 0;
  endtask

  task automatic test_read();
    check_req(1'b0, 65, 32'h0, 3, "read_miss");
    check_req(1'b0, 65, 32'h0, 0, "read_hit");
  endtask

  task automatic test_write();
    check_req(1'b1, 128, 32'h12345678, 2, "write");
  endtask

  task automatic test_timeout();
    check_req(1'b0, 100, 32'h0, -1, "rd_timeout");
    check_req(1'b0, 100, 32'h0, 1, "after_timeout");
    check_req(1'b0, 101, 32'h0, T - 1, "ack_at_limit");
    check_req(1'b1, 102, 32'hCAFEF00D, T, "wr_timeout");
  endtask

  task automatic test_reset_mid();
    int c0, rd;
    @(negedge clk);
    ack_dly = -1; cur_addr = 32'h320; cur_we = 1'b0; cur_wdata = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h320; bus.cpu_wdata = 0;
    @(negedge clk); bus.cpu_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_mid mem_req got=%b exp=1", bus.mem_req); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.cpu_busy !== 1'b0 || hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
      miscompares++; $display("FAIL rst_mid state got=%b%b cnt=%0d/%0d exp=00 0/0", bus.mem_req, bus.cpu_busy, hit_cnt, miss_cnt);
    end
    rst = 1'b0; ref_hit = 0; ref_miss = 0; stray_ack = 1'b1; c0 = n_cwe; rd = 0;
    @(negedge clk); stray_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.cpu_ready || bus.cpu_busy) rd++;
      @(negedge clk);
    end
    ack_dly = 0;
    vectors++;
    if (rd != 0 || n_cwe != c0) begin miscompares++; $display("FAIL rst_stray_ack ready_busy_cycles=%0d c_we=%0d exp=0/0", rd, n_cwe - c0); end
  endtask

  task automatic test_back_to_back();
    int n, cnt, last;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200; bus.cpu_wdata = 0;
    n = 0; cnt = 0; last = 0;
    while (n < 30 && cnt < 3) begin
      @(negedge clk); n++;
      if (bus.cpu_ready) begin
        cnt++; ref_hit = (ref_hit < 15) ? ref_hit + 1 : 15;
        vectors++;
        if (n - last != 3 || bus.cpu_rdata !== ref_mem[128]) begin
          miscompares++; $display("FAIL b2b gap got=%0d exp=3 rdata got=%h exp=%h", n - last, bus.cpu_rdata, ref_mem[128]);
        end
        last = n;
        if (cnt == 3) bus.cpu_req = 1'b0;
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.cpu_ready) cnt++;
    end
    vectors++;
    if (cnt != 3 || hit_cnt !== 4'(ref_hit)) begin miscompares++; $display("FAIL b2b pulses got=%0d exp=3 hit_cnt=%0d exp=%0d", cnt, hit_cnt, ref_hit); end
  endtask

  task automatic test_saturate();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; ref_hit = 0; ref_miss = 0;
    for (int i = 0; i < 20; i++) check_req(1'b0, 65, 32'h0, 0, "saturate");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int d;
      d = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 9));
      check_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom, d, "random");
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    for (int i = 0; i < 256; i++) begin ref_valid[i] = 1'b0; ref_mem[i] = init_word(i); end
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
